// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_pkg
//  Purpose  : Shared definitions for the reg_bank staging/active register
//             bank: the operation-mode encoding and the channel-select width
//             helper.
//  Revision : 1.0  initial release
// ============================================================================
package reg_pkg;

  // Operation applied to a staging register when a write is accepted.
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SHL  = 2'd1,
    SHR  = 2'd2,
    CLR  = 2'd3
  } mode_e;

  // Channel-select width: clog2 of the channel count, never below one bit,
  // so a single-channel bank still has a usable select port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : reg_pkg
`default_nettype wire

// File: rtl/reg_cell.sv
`default_nettype none
// ============================================================================
//  Module   : reg_cell
//  Purpose  : One channel of the register bank: a staging register that is
//             edited by LOAD/SHL/SHR/CLR operations, an active register that
//             copies the staging value on commit, and a dirty flag.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             sel           - operation accepted for this channel this cycle
//             mode          - operation to apply when sel is high
//             wr_data       - LOAD value
//             ser_in        - bit shifted in by SHL (LSB) / SHR (MSB)
//             commit        - copy staging into active, clear dirty
//             stg           - current staging value (flop output)
//             act           - current active value (flop output)
//             dirty         - staging modified since the last commit
//  Revision : 1.0  initial release
// ============================================================================
module reg_cell
  import reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ser_in,
  input  logic             commit,
  output logic [WIDTH-1:0] stg,
  output logic [WIDTH-1:0] act,
  output logic             dirty
);

  logic [WIDTH-1:0] stg_q, stg_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic             dirty_q, dirty_d;

  always_comb begin
    stg_d = stg_q;
    if (sel) begin
      case (mode)
        LOAD:    stg_d = wr_data;
        SHL:     stg_d = {stg_q[WIDTH-2:0], ser_in};
        SHR:     stg_d = {ser_in, stg_q[WIDTH-1:1]};
        CLR:     stg_d = '0;
        default: stg_d = stg_q;
      endcase
    end

    // Active takes the pre-write staging value, so a write coinciding with
    // commit lands in staging only.
    act_d = commit ? stg_q : act_q;

    // A same-cycle write wins over commit's clear: the written channel
    // remains dirty because its staging differs from what was just committed.
    dirty_d = dirty_q;
    if (commit) dirty_d = 1'b0;
    if (sel)    dirty_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q   <= '0;
      act_q   <= '0;
      dirty_q <= 1'b0;
    end else begin
      stg_q   <= stg_d;
      act_q   <= act_d;
      dirty_q <= dirty_d;
    end
  end

  assign stg   = stg_q;
  assign act   = act_q;
  assign dirty = dirty_q;

endmodule : reg_cell
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank
//  Purpose  : Bank of NUM_CH double-buffered registers. Writes edit per-channel
//             staging registers; commit copies all staging registers into the
//             active registers at once. Staging values can be read back with
//             one cycle of latency.
//  Ports    : clk, rst  - clock, synchronous active-high reset
//             wr_en     - request one staging operation this cycle
//             wr_ch     - target channel of the operation
//             mode      - LOAD=0, SHL=1, SHR=2, CLR=3
//             wr_data   - LOAD value
//             ser_in    - serial bit for SHL/SHR
//             commit    - copy every staging register to its active register
//             rd_ch     - channel whose staging value is read back
//             rd_data   - registered staging readback (0 for invalid rd_ch)
//             q         - active registers, channel k at [k*WIDTH +: WIDTH]
//             dirty     - per-channel staging-modified flag
//             err       - one-cycle flag for out-of-range wr_ch / rd_ch
//  Revision : 1.0  initial release
// ============================================================================
module reg_bank
  import reg_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [1:0]              mode,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    ser_in,
  input  logic                    commit,
  input  logic [CH_W-1:0]         rd_ch,
  output logic [WIDTH-1:0]        rd_data,
  output logic [NUM_CH*WIDTH-1:0] q,
  output logic [NUM_CH-1:0]       dirty,
  output logic                    err
);

  // Channel count at select width + 1 so the range check also works when
  // NUM_CH is an exact power of two.
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic [WIDTH-1:0]  stg [NUM_CH];
  logic [WIDTH-1:0]  act [NUM_CH];
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] cell_dirty;

  logic              wr_valid;
  logic              rd_valid;

  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              err_q, err_d;

  assign wr_valid = ({1'b0, wr_ch} < NUM_CH_L);
  assign rd_valid = ({1'b0, rd_ch} < NUM_CH_L);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign sel[k] = wr_en && wr_valid && (wr_ch == CH_W'(k));

    reg_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel[k]),
      .mode    (mode_e'(mode)),
      .wr_data (wr_data),
      .ser_in  (ser_in),
      .commit  (commit),
      .stg     (stg[k]),
      .act     (act[k]),
      .dirty   (cell_dirty[k])
    );

    assign q[k*WIDTH +: WIDTH] = act[k];
  end

  assign dirty = cell_dirty;

  // Readback samples the current staging value, so a write landing on the
  // same edge shows up one cycle later.
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_valid && (rd_ch == CH_W'(k))) rd_data_d = stg[k];
    end
    err_d = (wr_en && !wr_valid) || !rd_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  assign rd_data = rd_data_q;
  assign err     = err_q;

endmodule : reg_bank
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_bank
//  Purpose  : Directed self-checking bench for reg_bank. Instance a uses
//             WIDTH=8/NUM_CH=4, instance b uses WIDTH=8/NUM_CH=3 for the
//             out-of-range channel cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_bank;
  import reg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance a: NUM_CH=4
  logic        a_wr_en, a_ser_in, a_commit, a_err;
  logic [1:0]  a_wr_ch, a_mode, a_rd_ch;
  logic [7:0]  a_wr_data, a_rd_data;
  logic [31:0] a_q;
  logic [3:0]  a_dirty;

  // Instance b: NUM_CH=3
  logic        b_wr_en, b_ser_in, b_commit, b_err;
  logic [1:0]  b_wr_ch, b_mode, b_rd_ch;
  logic [7:0]  b_wr_data, b_rd_data;
  logic [23:0] b_q;
  logic [2:0]  b_dirty;

  int vec  = 0;
  int errs = 0;

  reg_bank #(.WIDTH(8), .NUM_CH(4)) dut_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_ch(a_wr_ch), .mode(a_mode),
    .wr_data(a_wr_data), .ser_in(a_ser_in), .commit(a_commit), .rd_ch(a_rd_ch),
    .rd_data(a_rd_data), .q(a_q), .dirty(a_dirty), .err(a_err)
  );

  reg_bank #(.WIDTH(8), .NUM_CH(3)) dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_ch(b_wr_ch), .mode(b_mode),
    .wr_data(b_wr_data), .ser_in(b_ser_in), .commit(b_commit), .rd_ch(b_rd_ch),
    .rd_data(b_rd_data), .q(b_q), .dirty(b_dirty), .err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vec++; if (a_q !== 32'h0) begin errs++; $display("FAIL reset_a_q: got %h want %h", a_q, 32'h0); end
    vec++; if (a_dirty !== 4'b0) begin errs++; $display("FAIL reset_a_dirty: got %b want %b", a_dirty, 4'b0); end
    vec++; if (a_rd_data !== 8'h0 || a_err !== 1'b0) begin errs++; $display("FAIL reset_a_rd_err: got %h/%b want 00/0", a_rd_data, a_err); end
    vec++; if (b_q !== 24'h0 || b_dirty !== 3'b0) begin errs++; $display("FAIL reset_b: got %h/%b want 000000/000", b_q, b_dirty); end
  endtask

  task automatic test_load_commit();
    a_wr_en = 1'b1; a_wr_ch = 2'd2; a_mode = LOAD; a_wr_data = 8'hA5;
    tick();
    a_wr_en = 1'b0;
    vec++; if (a_q !== 32'h0) begin errs++; $display("FAIL load_q_before_commit: got %h want %h", a_q, 32'h0); end
    vec++; if (a_dirty !== 4'b0100) begin errs++; $display("FAIL load_dirty: got %b want %b", a_dirty, 4'b0100); end
    a_commit = 1'b1;
    tick();
    a_commit = 1'b0;
    vec++; if (a_q !== 32'h00A50000) begin errs++; $display("FAIL load_q_after_commit: got %h want %h", a_q, 32'h00A50000); end
    vec++; if (a_dirty !== 4'b0000) begin errs++; $display("FAIL commit_dirty: got %b want %b", a_dirty, 4'b0000); end
  endtask

  task automatic test_shift();
    a_rd_ch = 2'd0;
    a_wr_en = 1'b1; a_wr_ch = 2'd0; a_mode = LOAD; a_wr_data = 8'h81;
    tick();
    vec++; if (a_rd_data !== 8'h00) begin errs++; $display("FAIL shift_rd_lag0: got %h want %h", a_rd_data, 8'h00); end
    a_mode = SHL; a_ser_in = 1'b1;
    tick();
    vec++; if (a_rd_data !== 8'h81) begin errs++; $display("FAIL shift_rd_load: got %h want %h", a_rd_data, 8'h81); end
    a_mode = SHR; a_ser_in = 1'b0;
    tick();
    vec++; if (a_rd_data !== 8'h03) begin errs++; $display("FAIL shift_rd_shl: got %h want %h", a_rd_data, 8'h03); end
    a_wr_en = 1'b0;
    tick();
    vec++; if (a_rd_data !== 8'h01) begin errs++; $display("FAIL shift_rd_shr: got %h want %h", a_rd_data, 8'h01); end
    vec++; if (a_dirty !== 4'b0001 || a_err !== 1'b0) begin errs++; $display("FAIL shift_dirty_err: got %b/%b want 0001/0", a_dirty, a_err); end
  endtask

  task automatic test_back_to_back();
    // ch1 staging=0x3C, then LOAD 0xFF coinciding with commit.
    a_wr_en = 1'b1; a_wr_ch = 2'd1; a_mode = LOAD; a_wr_data = 8'h3C;
    tick();
    a_wr_data = 8'hFF; a_commit = 1'b1;
    tick();
    a_wr_en = 1'b0; a_commit = 1'b0;
    vec++; if (a_q !== 32'h00A53C01) begin errs++; $display("FAIL collide_q: got %h want %h", a_q, 32'h00A53C01); end
    vec++; if (a_dirty !== 4'b0010) begin errs++; $display("FAIL collide_dirty: got %b want %b", a_dirty, 4'b0010); end
    a_rd_ch = 2'd1;
    tick();
    vec++; if (a_rd_data !== 8'hFF) begin errs++; $display("FAIL collide_stg: got %h want %h", a_rd_data, 8'hFF); end
  endtask

  task automatic test_clr();
    a_wr_en = 1'b1; a_wr_ch = 2'd3; a_mode = LOAD; a_wr_data = 8'h7E;
    tick();
    a_wr_en = 1'b0; a_commit = 1'b1;
    tick();
    a_commit = 1'b0;
    vec++; if (a_q !== 32'h7EA5FF01) begin errs++; $display("FAIL clr_setup_q: got %h want %h", a_q, 32'h7EA5FF01); end
    a_wr_en = 1'b1; a_wr_ch = 2'd3; a_mode = CLR; a_rd_ch = 2'd3;
    tick();
    a_wr_en = 1'b0;
    vec++; if (a_dirty !== 4'b1000) begin errs++; $display("FAIL clr_dirty: got %b want %b", a_dirty, 4'b1000); end
    vec++; if (a_q[31:24] !== 8'h7E) begin errs++; $display("FAIL clr_q_held: got %h want %h", a_q[31:24], 8'h7E); end
    vec++; if (a_rd_data !== 8'h7E) begin errs++; $display("FAIL clr_rd_lag: got %h want %h", a_rd_data, 8'h7E); end
    tick();
    vec++; if (a_rd_data !== 8'h00) begin errs++; $display("FAIL clr_stg: got %h want %h", a_rd_data, 8'h00); end
    a_commit = 1'b1;
    tick();
    a_commit = 1'b0;
    vec++; if (a_q !== 32'h00A5FF01 || a_dirty !== 4'b0) begin errs++; $display("FAIL clr_commit: got %h/%b want 00a5ff01/0000", a_q, a_dirty); end
  endtask

  task automatic test_out_of_range();
    b_wr_en = 1'b1; b_mode = LOAD; b_wr_ch = 2'd0; b_wr_data = 8'h33;
    tick();
    b_wr_ch = 2'd1; b_wr_data = 8'h22;
    tick();
    b_wr_en = 1'b0; b_commit = 1'b1;
    tick();
    b_commit = 1'b0;
    vec++; if (b_q !== 24'h002233 || b_dirty !== 3'b0 || b_err !== 1'b0) begin errs++; $display("FAIL oor_setup: got %h/%b/%b want 002233/000/0", b_q, b_dirty, b_err); end
    b_wr_en = 1'b1; b_wr_ch = 2'd3; b_wr_data = 8'h55; b_rd_ch = 2'd0;
    tick();
    b_wr_en = 1'b0;
    vec++; if (b_err !== 1'b1) begin errs++; $display("FAIL oor_wr_err: got %b want 1", b_err); end
    vec++; if (b_dirty !== 3'b000 || b_q !== 24'h002233) begin errs++; $display("FAIL oor_wr_state: got %b/%h want 000/002233", b_dirty, b_q); end
    vec++; if (b_rd_data !== 8'h33) begin errs++; $display("FAIL oor_rd_ch0: got %h want %h", b_rd_data, 8'h33); end
    tick();
    vec++; if (b_err !== 1'b0) begin errs++; $display("FAIL oor_wr_err_pulse: got %b want 0", b_err); end
    b_commit = 1'b1;
    tick();
    b_commit = 1'b0;
    vec++; if (b_q !== 24'h002233) begin errs++; $display("FAIL oor_stg_untouched: got %h want %h", b_q, 24'h002233); end
    b_rd_ch = 2'd3;
    tick();
    vec++; if (b_rd_data !== 8'h00 || b_err !== 1'b1) begin errs++; $display("FAIL oor_rd: got %h/%b want 00/1", b_rd_data, b_err); end
    b_rd_ch = 2'd1;
    tick();
    vec++; if (b_rd_data !== 8'h22 || b_err !== 1'b0) begin errs++; $display("FAIL oor_rd_recover: got %h/%b want 22/0", b_rd_data, b_err); end
  endtask

  task automatic test_reset_priority();
    a_wr_en = 1'b1; a_mode = LOAD;
    for (int k = 0; k < 4; k++) begin
      a_wr_ch = 2'(k);
      a_wr_data = 8'h10 + 8'(k);
      tick();
    end
    a_wr_en = 1'b0; a_commit = 1'b1; a_rd_ch = 2'd0;
    tick();
    a_commit = 1'b0;
    vec++; if (a_q !== 32'h13121110) begin errs++; $display("FAIL rstp_setup_q: got %h want %h", a_q, 32'h13121110); end
    rst = 1'b1; a_wr_en = 1'b1; a_wr_ch = 2'd0; a_wr_data = 8'hFF; a_commit = 1'b1;
    tick();
    rst = 1'b0; a_wr_en = 1'b0; a_commit = 1'b0;
    vec++; if (a_q !== 32'h0) begin errs++; $display("FAIL rstp_q: got %h want %h", a_q, 32'h0); end
    vec++; if (a_rd_data !== 8'h0 || a_dirty !== 4'b0 || a_err !== 1'b0) begin errs++; $display("FAIL rstp_rd_dirty_err: got %h/%b/%b want 00/0000/0", a_rd_data, a_dirty, a_err); end
    tick();
    vec++; if (a_rd_data !== 8'h0) begin errs++; $display("FAIL rstp_stg_cleared: got %h want %h", a_rd_data, 8'h0); end
  endtask

  initial begin
    rst = 1'b1;
    a_wr_en = 1'b0; a_wr_ch = '0; a_mode = '0; a_wr_data = '0; a_ser_in = 1'b0; a_commit = 1'b0; a_rd_ch = '0;
    b_wr_en = 1'b0; b_wr_ch = '0; b_mode = '0; b_wr_data = '0; b_ser_in = 1'b0; b_commit = 1'b0; b_rd_ch = '0;
    test_reset();
    test_load_commit();
    test_shift();
    test_back_to_back();
    test_clr();
    test_out_of_range();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_reg_bank
`default_nettype wire
